// File: rtl/package_settings.sv
// package_settings: shared CORDIC datapath width, gain-compensation constants and result bundle type.
package package_settings;
  localparam int FULL_SIZE = 16;
  localparam int CORDIC_GAIN_COMP = 19898;
  localparam int CORDIC_GAIN_FRAC_BITS = 15;
  typedef struct packed {
    logic signed [FULL_SIZE-1:0] magnitude;
    logic signed [FULL_SIZE-1:0] residual_q;
    logic signed [FULL_SIZE-1:0] phase;
  } cordic_result_t;
endpackage

// File: rtl/cordic_result_fifo.sv
// cordic_result_fifo: first-word-fall-through FIFO of CORDIC results with occupancy level.
module cordic_result_fifo
  import package_settings::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  cordic_result_t           wr_data,
  input  logic                     rd_en,
  output cordic_result_t           rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  cordic_result_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign do_rd = rd_en && !empty;
  // a full FIFO still accepts a write when the head leaves on the same edge
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_wr);
      rd_ptr <= rd_ptr + AW'(do_rd);
      level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
endmodule

// File: rtl/cordic_result_post_process.sv
// cordic_result_post_process: removes CORDIC gain from I, then buffers results for a valid/ready consumer.
module cordic_result_post_process
  import package_settings::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAIN_COMP = CORDIC_GAIN_COMP,
  parameter int GAIN_FRAC_BITS = CORDIC_GAIN_FRAC_BITS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [FULL_SIZE-1:0]    in_data_i,
  input  logic signed [FULL_SIZE-1:0]    in_data_q,
  input  logic signed [FULL_SIZE-1:0]    in_data_theta,
  input  logic                           in_valid,
  input  logic                           out_ready,
  input  logic                           clear_overflow,
  output logic signed [FULL_SIZE-1:0]    out_magnitude,
  output logic signed [FULL_SIZE-1:0]    out_residual_q,
  output logic signed [FULL_SIZE-1:0]    out_phase,
  output logic                           out_valid,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           overflow
);
  localparam int PW = FULL_SIZE + 18;
  localparam logic signed [PW-1:0] GAIN = PW'(GAIN_COMP);
  localparam logic signed [PW-1:0] HALF = PW'(2 ** (GAIN_FRAC_BITS - 1));
  localparam logic signed [PW-1:0] MAX_V = {{(PW-FULL_SIZE+1){1'b0}}, {(FULL_SIZE-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_V = ~MAX_V;
  logic signed [PW-1:0] prod, shifted;
  logic signed [FULL_SIZE-1:0] s1_q, s1_theta, sat;
  logic s1_valid, s2_valid, empty, full, rd;
  cordic_result_t s2_data, head;
  assign shifted = (prod + HALF) >>> GAIN_FRAC_BITS;
  assign sat = shifted > MAX_V ? MAX_V[FULL_SIZE-1:0] :
               shifted < MIN_V ? MIN_V[FULL_SIZE-1:0] : shifted[FULL_SIZE-1:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_valid <= 1'b0;
      prod <= '0;
      s1_q <= '0;
      s1_theta <= '0;
      s2_valid <= 1'b0;
      s2_data <= '0;
    end else begin
      s1_valid <= in_valid;
      prod <= PW'(in_data_i) * GAIN;
      s1_q <= in_data_q;
      s1_theta <= in_data_theta;
      s2_valid <= s1_valid;
      s2_data <= '{magnitude: sat, residual_q: s1_q, phase: s1_theta};
    end
  assign rd = out_ready && !empty;
  always_ff @(posedge clk or posedge reset)
    if (reset) overflow <= 1'b0;
    else if (s2_valid && full && !rd) overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  cordic_result_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(s2_valid),
    .wr_data(s2_data),
    .rd_en(rd),
    .rd_data(head),
    .empty(empty),
    .full(full),
    .level(fifo_level)
  );
  assign out_valid = !empty;
  assign out_magnitude = out_valid ? head.magnitude : '0;
  assign out_residual_q = out_valid ? head.residual_q : '0;
  assign out_phase = out_valid ? head.phase : '0;
endmodule

// File: tb/tb_cordic_result_post_process.sv
// tb_cordic_result_post_process: randomized and directed checks against a queue-based reference model.
module tb_cordic_result_post_process;
  import package_settings::*;
  logic clk = 0, reset = 1, iv = 0, rdy = 0, clr = 0;
  logic signed [15:0] ii = 0, iq = 0, it = 0;
  logic signed [15:0] mag, rq, ph, mag2, rq2, ph2;
  logic ov, ov2, ovf, ovf2;
  logic [2:0] lvl, lvl2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  cordic_result_post_process dut (
    .clk(clk), .reset(reset), .in_data_i(ii), .in_data_q(iq), .in_data_theta(it),
    .in_valid(iv), .out_ready(rdy), .clear_overflow(clr), .out_magnitude(mag),
    .out_residual_q(rq), .out_phase(ph), .out_valid(ov), .fifo_level(lvl), .overflow(ovf));
  cordic_result_post_process #(.GAIN_COMP(40000)) dut_sat (
    .clk(clk), .reset(reset), .in_data_i(ii), .in_data_q(iq), .in_data_theta(it),
    .in_valid(iv), .out_ready(rdy), .clear_overflow(clr), .out_magnitude(mag2),
    .out_residual_q(rq2), .out_phase(ph2), .out_valid(ov2), .fifo_level(lvl2), .overflow(ovf2));

  wire [52:0] obs = {ov, lvl, ovf, mag, rq, ph};

  bit p1v, p2v, movf;
  cordic_result_t p1, p2;
  cordic_result_t fq[$];

  function automatic logic signed [15:0] ref_mag(input logic signed [15:0] i, input longint g);
    longint p, r;
    p = longint'(i) * g + 16384;
    r = (p >= 0) ? p / 32768 : -((-p + 32767) / 32768);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  function automatic logic [52:0] expv();
    cordic_result_t h;
    h = '0;
    if (fq.size() > 0) h = fq[0];
    return {fq.size() > 0, 3'(fq.size()), movf, h};
  endfunction

  task automatic model_clear();
    p1v = 0; p2v = 0; movf = 0; fq.delete();
  endtask

  task automatic step();
    bit rd;
    rd = rdy && fq.size() > 0;
    if (p2v && fq.size() == 4 && !rd) movf = 1;
    else if (clr) movf = 0;
    if (rd) void'(fq.pop_front());
    if (p2v && (fq.size() < 4)) fq.push_back(p2);
    p2v = p1v; p2 = p1;
    p1v = iv; p1 = '{ref_mag(ii, 19898), iq, it};
    @(posedge clk); @(negedge clk);
  endtask

  task automatic rst();
    reset = 1; iv = 0; clr = 0;
    #1 model_clear();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (obs !== 53'd0) begin errors++; $display("FAIL reset_state got %h exp 0", obs); end
    model_clear();
    reset = 0;
  endtask

  task automatic test_gain();
    logic signed [15:0] vals [3] = '{16384, -1, 32767};
    logic signed [15:0] exps [3] = '{9949, -1, 19897};
    rdy = 1;
    for (int k = 0; k < 3; k++) begin
      ii = vals[k]; iq = 16'(3 + k); it = 16'sd8192; iv = 1;
      for (int c = 0; c < 5; c++) begin
        step();
        iv = 0;
        checks++;
        if (obs !== expv()) begin errors++; $display("FAIL gain k%0d c%0d got %h exp %h", k, c, obs, expv()); end
        if (c == 2) begin
          checks++;
          if (!(ov === 1 && mag === exps[k] && rq === 16'(3 + k) && ph === 16'sd8192)) begin
            errors++; $display("FAIL gain_value k%0d got v%b m%0d q%0d p%0d exp m%0d", k, ov, mag, rq, ph, exps[k]);
          end
        end
        if (c == 3) begin
          checks++;
          if (ov !== 0) begin errors++; $display("FAIL gain_one_cycle k%0d got %b exp 0", k, ov); end
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] vals [2] = '{32767, -32768};
    logic signed [15:0] exps [2] = '{32767, -32768};
    rst();
    rdy = 1;
    for (int k = 0; k < 2; k++) begin
      ii = vals[k]; iq = 0; it = 0; iv = 1;
      step(); iv = 0; step(); step();
      checks++;
      if (!(ov2 === 1 && mag2 === exps[k] && mag2 === ref_mag(vals[k], 40000))) begin
        errors++; $display("FAIL saturation k%0d got v%b m%0d exp %0d", k, ov2, mag2, exps[k]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    rst();
    rdy = 0;
    for (int c = 0; c < 8; c++) begin
      iv = c < 5; ii = 16'(100 + c); iq = 16'(c); it = 16'(-c);
      step();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL backpressure c%0d got %h exp %h", c, obs, expv()); end
    end
    checks++;
    if (!(lvl === 3'd4 && ovf === 1)) begin errors++; $display("FAIL bp_full got lvl%0d ovf%b exp lvl4 ovf1", lvl, ovf); end
    rdy = 1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (!(ov === (c < 4) && lvl === 3'(4 - (c < 4 ? c : 4)) && (c == 4 || mag === ref_mag(16'(100 + c), 19898)))) begin
        errors++; $display("FAIL drain c%0d got v%b lvl%0d m%0d", c, ov, lvl, mag);
      end
      step();
    end
    checks++;
    if (!(ov === 0 && lvl === 0)) begin errors++; $display("FAIL drained got v%b lvl%0d exp v0 lvl0", ov, lvl); end
  endtask

  task automatic test_overflow_clear();
    clr = 1; step(); clr = 0;
    checks++;
    if (ovf !== 0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf); end
    rdy = 0; clr = 1;
    for (int c = 0; c < 7; c++) begin
      iv = c < 5; ii = 16'($urandom); iq = 16'($urandom); it = 16'($urandom);
      step();
    end
    clr = 0;
    checks++;
    if (!(ovf === 1 && obs === expv())) begin errors++; $display("FAIL ovf_set_wins got %h exp %h", obs, expv()); end
    rdy = 1;
    for (int c = 0; c < 5; c++) step();
    clr = 1; step(); clr = 0;
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL ovf_after_drain got %h exp %h", obs, expv()); end
  endtask

  task automatic test_full_rw();
    rst();
    rdy = 0;
    for (int c = 0; c < 20; c++) begin
      iv = c < 16; ii = 16'($urandom); iq = 16'($urandom); it = 16'($urandom);
      if (fq.size() == 4) rdy = 1;
      step();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL full_rw c%0d got %h exp %h", c, obs, expv()); end
      if (c >= 5 && c < 17) begin
        checks++;
        if (!(lvl === 3'd4 && ovf === 0)) begin errors++; $display("FAIL full_rw_level c%0d got lvl%0d ovf%b exp lvl4 ovf0", c, lvl, ovf); end
      end
    end
  endtask

  task automatic test_reset_mid();
    rst();
    rdy = 0;
    for (int c = 0; c < 5; c++) begin
      iv = 1; ii = 16'(200 + c); iq = 0; it = 0;
      step();
    end
    iv = 0;
    checks++;
    if (!(lvl === 3'd3 && ov === 1)) begin errors++; $display("FAIL mid_prefill got lvl%0d exp 3", lvl); end
    #2 reset = 1;
    #1;
    checks++;
    if (!(ov === 0 && lvl === 0 && mag === 0)) begin errors++; $display("FAIL mid_reset_async got v%b lvl%0d m%0d exp 0", ov, lvl, mag); end
    model_clear();
    @(negedge clk);
    reset = 0; rdy = 1;
    iv = 1; ii = 16'sd16384; iq = 16'sd7; it = -16'sd5;
    for (int c = 0; c < 4; c++) begin
      step();
      iv = 0;
      checks++;
      if (!(obs === expv() && ov === (c == 2))) begin errors++; $display("FAIL mid_latency c%0d got %h exp %h", c, obs, expv()); end
    end
  endtask

  task automatic test_random();
    rst();
    for (int c = 0; c < 400; c++) begin
      iv = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 2) != 0;
      clr = $urandom_range(0, 15) == 0;
      ii = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? 16'sd32767 : -16'sd32768) : 16'($urandom);
      iq = 16'($urandom); it = 16'($urandom);
      step();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL random c%0d got %h exp %h", c, obs, expv()); end
    end
    iv = 0; clr = 0;
  endtask

  initial begin
    test_reset();
    test_gain();
    test_saturation();
    test_backpressure();
    test_overflow_clear();
    test_full_rw();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_result_post_process.md
Name: cordic_result_post_process

Overview:
- Sits directly downstream of the CORDIC kernel and consumes its result bundle: output_data_i, output_data_q, output_data_theta and ouput_data_valid.
- Removes the CORDIC gain from the I channel in a 2-stage multiply/round/saturate pipeline.
- Buffers results in a small FIFO so the consumer can apply valid/ready backpressure, which the kernel itself cannot.
- Reports FIFO level and a sticky overflow flag for dropped results.

Parameters:
- FIFO_DEPTH, 4, number of result entries; power of 2, minimum 2.
- GAIN_COMP, 19898, unsigned gain-compensation constant (0.60725 in Q0.GAIN_FRAC_BITS), at most 17 bits.
- GAIN_FRAC_BITS, 15, number of fractional bits in GAIN_COMP.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data_i  input  FULL_SIZE  signed kernel I result (magnitude times K in vectoring mode).
- in_data_q  input  FULL_SIZE  signed kernel Q residual.
- in_data_theta  input  FULL_SIZE  signed kernel angle.
- in_valid  input  1  kernel result valid; single-cycle qualifier, no backpressure.
- out_ready  input  1  consumer accepts the head entry this cycle.
- clear_overflow  input  1  synchronous clear of overflow.
- out_magnitude  output  FULL_SIZE  signed gain-compensated I.
- out_residual_q  output  FULL_SIZE  Q residual, delayed to align with out_magnitude, not scaled.
- out_phase  output  FULL_SIZE  theta, delayed to align with out_magnitude.
- out_valid  output  1  FIFO non-empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current number of occupied entries.
- overflow  output  1  sticky; set when a result is dropped.

Behaviour:
- Reset values (asynchronous): all pipeline valids 0, FIFO pointers 0, fifo_level 0, overflow 0. Data outputs read 0.
- Reset mid-operation: in-flight pipeline samples and all FIFO contents are discarded. out_valid falls immediately on reset assertion, not on the next clock edge.
- Stage 1 (sampling edge E0):
  - product = in_data_i * signed'({1'b0, GAIN_COMP}), width FULL_SIZE+18.
  - q, theta and valid are registered alongside the product.
- Stage 2 (edge E1):
  - rounded = (product + 2^(GAIN_FRAC_BITS-1)) >>> GAIN_FRAC_BITS, arithmetic shift, round half toward +inf.
  - Saturate to the signed FULL_SIZE range [-2^(FULL_SIZE-1), 2^(FULL_SIZE-1)-1].
- FIFO write at edge E2. out_valid is high after E2 when the FIFO was empty, giving a latency of 3 rising edges from the in_valid sample.
- Full throughput: one result per clock.
- FIFO is first-word-fall-through:
  - out_magnitude, out_residual_q and out_phase show the head entry whenever out_valid=1.
  - These outputs are forced to 0 when out_valid=0.
- Read occurs on an edge where out_valid and out_ready are both 1; head advances.
- Write occurs on an edge where the stage-2 valid is 1.
- Full with a write and no read: the write is dropped, contents unchanged, overflow set to 1.
- Full with a write and a read on the same edge: both happen, no drop, level stays FIFO_DEPTH.
- Empty with out_ready=1: no effect.
- Pointers wrap modulo FIFO_DEPTH; fifo_level is tracked with an extra bit so full and empty are distinguishable.
- overflow clears on an edge with clear_overflow=1. If a drop happens on the same edge, set wins.
- Data order is strictly preserved; entries are never reordered or duplicated.

Decomposition:
- package_settings (existing) supplies FULL_SIZE.
- Add to package_settings:
  - constants CORDIC_GAIN_COMP=19898 and CORDIC_GAIN_FRAC_BITS=15, used as the parameter defaults.
  - typedef cordic_result_t, a packed struct {magnitude, residual_q, phase}, each signed [FULL_SIZE-1:0].
- One sub-module: cordic_result_fifo.
  - Parameterised FWFT FIFO of cordic_result_t.
  - Ports: clk, reset, wr_en, wr_data, rd_en, rd_data, empty, full, level.
- The pipeline, saturation and overflow logic stay in the top module.

Test Plan (FULL_SIZE=16):
- Gain path: in_valid pulse with i=16384, q=3, theta=8192, out_ready=1 -> out_valid rises 3 edges later with magnitude=9949, residual_q=3, phase=8192, for one cycle. Also i=-1 -> magnitude -1; i=32767 -> 19897.
- Saturation (override GAIN_COMP=40000): i=32767 -> 32767; i=-32768 -> -32768.
- Backpressure (out_ready=0, 5 back-to-back results with i=100..104):
  - First 4 are stored: level=4; the 5th is dropped: overflow=1.
  - Then out_ready=1 drains the 4 stored results (i=100..103) in order, level counts down to 0, then out_valid=0.
- Full plus simultaneous read/write: with FIFO full, out_ready=1 held and results streaming every cycle -> level stays 4, overflow stays 0, no gaps in output order.
- Reset mid-stream: assert reset between edges with 2 results in the pipeline and 3 in the FIFO -> out_valid=0 and fifo_level=0 before the next edge. After release, the first new result appears with 3-edge latency.
- Overflow clear: pulse clear_overflow with no drop -> overflow=0. clear_overflow coincident with a drop -> overflow stays 1.
